// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential 16/8 restoring divider.
// Used by the divider top and by anything that needs its state encoding.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 16;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned CNT_W      = $clog2(DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only if it did not borrow.
module div_restoring_step #(
    parameter int unsigned DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   rem,
    input  logic                 q_msb,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   next_rem,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] trial;

    always_comb begin
        shifted  = {rem, q_msb};
        // One spare MSB turns the subtraction's borrow into a plain sign bit.
        trial    = shifted - {2'b00, divisor};
        q_bit    = ~trial[DIVISOR_W+1];
        next_rem = q_bit ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on both operand and result sides.
module seq_divider_16by8 #(
    parameter int unsigned DIVIDEND_W = div_pkg::DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = div_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    import div_pkg::div_state_t;
    import div_pkg::IDLE;
    import div_pkg::CALC;
    import div_pkg::DONE;

    localparam int unsigned CntW = $clog2(DIVIDEND_W);

    div_state_t            state_q, state_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVISOR_W-1:0]  div_q, div_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  dbz_q, dbz_d;

    logic [DIVISOR_W:0]    step_rem;
    logic                  step_q_bit;

    div_restoring_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem      (rem_q),
        .q_msb    (q_q[DIVIDEND_W-1]),
        .divisor  (div_q),
        .next_rem (step_rem),
        .q_bit    (step_q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        rem_d     = rem_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Held low while reset is asserted, even though the state is already IDLE.
                in_ready = ~rst;
                if (in_valid && in_ready) begin
                    div_d = divisor;
                    cnt_d = CntW'(DIVIDEND_W - 1);
                    dbz_d = (divisor == '0);
                    if (divisor == '0) begin
                        q_d     = '1;
                        rem_d   = {1'b0, dividend[DIVISOR_W-1:0]};
                        state_d = DONE;
                    end else begin
                        q_d     = dividend;
                        rem_d   = '0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                // The quotient register doubles as the dividend shifter.
                q_d   = {q_q[DIVIDEND_W-2:0], step_q_bit};
                rem_d = step_rem;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient    = q_q;
    assign remainder   = rem_q[DIVISOR_W-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Self-checking bench for seq_divider_16by8: directed corner cases, back-pressure,
// mid-operation reset, random pairs and multiply-then-divide round trips.
module tb_seq_divider_16by8;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_divider_16by8 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        check_eq("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("quotient", 32'(quotient), 32'(e.q));
            check_eq("remainder", 32'(remainder), 32'(e.r));
            check_eq("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        end
    endtask

    // Entered and left on a negedge with the DUT idle.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                         input logic [7:0] er, input int hold, input bit poke);
        exp_t e;
        int   lat;
        int   exp_lat;
        e.q     = eq;
        e.r     = er;
        e.dbz   = (b == 8'd0);
        exp_lat = (b == 8'd0) ? 1 : 17;
        check_eq("in_ready_idle", 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            if (poke) begin
                check_eq("in_ready_busy", 32'(in_ready), 32'd0);
                in_valid = 1'b1;
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", 32'(lat), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            in_valid = poke;
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
            check_eq("hold_q", 32'(quotient), 32'(eq));
            check_eq("hold_r", 32'(remainder), 32'(er));
            check_eq("hold_dbz", 32'(div_by_zero), 32'(e.dbz));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        compare_out();
        @(negedge clk);
        check_eq("valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  m;
        exp_t        e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_quotient", 32'(quotient), 32'd0);
        check_eq("rst_remainder", 32'(remainder), 32'd0);
        check_eq("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        do_op(16'd1000, 8'd7, 16'd142, 8'd6, 0, 1'b0);
        do_op(16'd65535, 8'd1, 16'd65535, 8'd0, 0, 1'b0);
        do_op(16'd65535, 8'd255, 16'd257, 8'd0, 0, 1'b0);
        do_op(16'd5, 8'd9, 16'd0, 8'd5, 0, 1'b0);
        do_op(16'h1234, 8'd0, 16'hFFFF, 8'h34, 0, 1'b0);
        do_op(16'd100, 8'd10, 16'd10, 8'd0, 0, 1'b0);
        do_op(16'd1000, 8'd7, 16'd142, 8'd6, 10, 1'b1);
        do_op(16'hABCD, 8'd0, 16'hFFFF, 8'hCD, 3, 1'b1);
        do_op(16'd0, 8'd200, 16'd0, 8'd0, 0, 1'b1);

        // Abort 1000/7 in its eighth CALC cycle.
        e.q       = 16'd142;
        e.r       = 8'd6;
        e.dbz     = 1'b0;
        dividend  = 16'd1000;
        divisor   = 8'd7;
        in_valid  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_quotient", 32'(quotient), 32'd0);
        @(negedge clk);
        check_eq("mid_rst_in_ready_held", 32'(in_ready), 32'd0);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("mid_rst_release_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_no_result", 32'(out_valid), 32'd0);
        do_op(16'h2A10, 8'h40, 16'd168, 8'd16, 0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            a = 16'($urandom);
            b = (i % 50 == 0) ? 8'd0 : 8'($urandom);
            if (b == 8'd0) do_op(a, b, 16'hFFFF, a[7:0], 0, 1'b0);
            else           do_op(a, b, a / 16'(b), 8'(a % 16'(b)), 0, 1'b0);
        end

        // Product of two bytes divided by one factor returns the other.
        for (int bi = 1; bi < 256; bi++) begin
            b = 8'(bi);
            m = 8'($urandom);
            do_op(16'(m) * 16'(b), b, 16'(m), 8'd0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
